// File: rtl/prach_pkg.sv
// Shared types and constants for the PRACH DDC timing/configuration controller.
package prach_pkg;

    localparam int NUM_CHN      = 8;
    localparam int NUM_ANT      = 3;
    localparam int CLK_PER_SLOT = 4;
    localparam int FCW_W        = 16;

    localparam int CHN_W     = 8;
    localparam int ANT_W     = 2;
    localparam int CHN_SEL_W = $clog2(NUM_CHN);
    localparam int ANT_SEL_W = $clog2(NUM_ANT);
    localparam int DIV_W     = (CLK_PER_SLOT > 1) ? $clog2(CLK_PER_SLOT) : 1;

    localparam int ERR_REALIGN = 0;
    localparam int ERR_WR_DROP = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    typedef logic [NUM_ANT-1:0][NUM_CHN-1:0][FCW_W-1:0] fcw_table_t;

endpackage

// File: rtl/prach_fcw_bank.sv
// FCW shadow/active table pair: validated shadow writes and whole-table copy to active.
module prach_fcw_bank
    import prach_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [ANT_W-1:0] wr_ant,
    input  logic [CHN_W-1:0] wr_chn,
    input  logic [FCW_W-1:0] wr_data,
    input  logic             busy,
    input  logic             copy,
    output fcw_table_t       active,
    output logic             wr_drop
);

    fcw_table_t shadow_q, shadow_d;
    fcw_table_t active_q, active_d;
    logic       wr_ok;

    always_comb begin
        wr_ok   = wr_en && !busy && (int'(wr_ant) < NUM_ANT) && (int'(wr_chn) < NUM_CHN);
        wr_drop = wr_en && !wr_ok;
        shadow_d = shadow_q;
        if (wr_ok) begin
            shadow_d[wr_ant[ANT_SEL_W-1:0]][wr_chn[CHN_SEL_W-1:0]] = wr_data;
        end
        // Copy from the next shadow so a write in the commit cycle is included.
        active_d = copy ? shadow_d : active_q;
    end

    // NOTE: both tables are plain flops and must read zero after reset, so they are reset like any other state.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign active = active_q;

endmodule

// File: rtl/prach_ddc_ctrl.sv
// PRACH DDC controller: frame-aligned TDM strobe/channel/sync generation and FCW commit timing.
// Define PRACH_DDC_CTRL_STATS_EN to add the frame_cnt and realign_cnt statistics outputs.
module prach_ddc_ctrl
    import prach_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             run_en,
    input  logic             frame_sync,
    input  logic             fcw_wr,
    input  logic [ANT_W-1:0] fcw_wr_ant,
    input  logic [CHN_W-1:0] fcw_wr_chn,
    input  logic [FCW_W-1:0] fcw_wr_data,
    input  logic             fcw_commit,
    output logic             fcw_busy,
    output logic             commit_done,
    output logic             ddc_dv,
    output logic [CHN_W-1:0] ddc_chn,
    output logic             ddc_sync,
    output fcw_table_t       ddc_fcw,
    output logic [1:0]       err_flags
`ifdef PRACH_DDC_CTRL_STATS_EN
    ,
    output logic [31:0]      frame_cnt,
    output logic [15:0]      realign_cnt
`endif
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_SLOT - 1);
    localparam logic [CHN_W-1:0] CHN_LAST = CHN_W'(NUM_CHN - 1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CHN_W-1:0] chn_q, chn_d;
    logic             dv_q, dv_d;
    logic             sync_q, sync_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       err_q, err_d;
    logic             boundary, realign, apply, in_run, wr_drop;

    prach_fcw_bank u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fcw_wr),
        .wr_ant  (fcw_wr_ant),
        .wr_chn  (fcw_wr_chn),
        .wr_data (fcw_wr_data),
        .busy    (busy_q),
        .copy    (apply),
        .active  (ddc_fcw),
        .wr_drop (wr_drop)
    );

    always_comb begin
        // NOTE: every combinational output is given a default first so no path can infer a latch.
        state_d  = state_q;
        div_d    = div_q;
        chn_d    = chn_q;
        dv_d     = 1'b0;
        sync_d   = 1'b0;
        realign  = 1'b0;
        if (!run_en) begin
            state_d = IDLE;
            div_d   = '0;
            chn_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: state_d = WAIT;
                WAIT: begin
                    if (frame_sync) begin
                        state_d = RUN;
                        div_d   = '0;
                        chn_d   = '0;
                        dv_d    = 1'b1;
                        sync_d  = 1'b1;
                    end
                end
                RUN: begin
                    div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
                    dv_d  = (div_d == '0);
                    if (dv_d) begin
                        chn_d = (chn_q == CHN_LAST) ? '0 : chn_q + CHN_W'(1);
                    end
                    // A frame_sync that does not land on a natural chn-0 strobe restarts the frame.
                    if (frame_sync && !(dv_d && chn_d == '0)) begin
                        div_d   = '0;
                        chn_d   = '0;
                        dv_d    = 1'b1;
                        sync_d  = 1'b1;
                        realign = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        boundary = (state_d == RUN) && dv_d && (chn_d == '0);
        in_run   = (state_q == RUN);
        apply    = busy_q ? (!in_run || boundary) : (fcw_commit && !in_run);
        busy_d   = !apply && (busy_q || fcw_commit);
        done_d   = apply;
        if (apply && in_run) begin
            sync_d = 1'b1;
        end

        err_d = err_q;
        if (realign) err_d[ERR_REALIGN] = 1'b1;
        if (wr_drop) err_d[ERR_WR_DROP] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking ones belong in always_comb.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            chn_q   <= '0;
            dv_q    <= 1'b0;
            sync_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            chn_q   <= chn_d;
            dv_q    <= dv_d;
            sync_q  <= sync_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign fcw_busy    = busy_q;
    assign commit_done = done_q;
    assign ddc_dv      = dv_q;
    assign ddc_chn     = chn_q;
    assign ddc_sync    = sync_q;
    assign err_flags   = err_q;

`ifdef PRACH_DDC_CTRL_STATS_EN
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] realign_cnt_q, realign_cnt_d;

    always_comb begin
        frame_cnt_d   = frame_cnt_q + 32'(boundary);
        realign_cnt_d = (realign && realign_cnt_q != '1) ? realign_cnt_q + 16'd1 : realign_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q   <= '0;
            realign_cnt_q <= '0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            realign_cnt_q <= realign_cnt_d;
        end
    end

    assign frame_cnt   = frame_cnt_q;
    assign realign_cnt = realign_cnt_q;
`endif

endmodule

// File: tb/tb_prach_ddc_ctrl.sv
// Self-checking bench for prach_ddc_ctrl: directed steps plus random traffic against a frame-arithmetic model.
`timescale 1ns/1ps
module tb_prach_ddc_ctrl;
    import prach_pkg::*;

    localparam int FRAME_CYC = CLK_PER_SLOT * NUM_CHN;
    typedef logic [$bits(fcw_table_t)-1:0] cmp_t;

    logic             clk = 1'b0;
    logic             rst, run_en, frame_sync, fcw_wr, fcw_commit;
    logic [1:0]       fcw_wr_ant;
    logic [7:0]       fcw_wr_chn;
    logic [FCW_W-1:0] fcw_wr_data;
    logic             fcw_busy, commit_done, ddc_dv, ddc_sync;
    logic [7:0]       ddc_chn;
    fcw_table_t       ddc_fcw;
    logic [1:0]       err_flags;
`ifdef PRACH_DDC_CTRL_STATS_EN
    logic [31:0]      frame_cnt;
    logic [15:0]      realign_cnt;
`endif

    prach_ddc_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .run_en      (run_en),
        .frame_sync  (frame_sync),
        .fcw_wr      (fcw_wr),
        .fcw_wr_ant  (fcw_wr_ant),
        .fcw_wr_chn  (fcw_wr_chn),
        .fcw_wr_data (fcw_wr_data),
        .fcw_commit  (fcw_commit),
        .fcw_busy    (fcw_busy),
        .commit_done (commit_done),
        .ddc_dv      (ddc_dv),
        .ddc_chn     (ddc_chn),
        .ddc_sync    (ddc_sync),
        .ddc_fcw     (ddc_fcw),
        .err_flags   (err_flags)
`ifdef PRACH_DDC_CTRL_STATS_EN
        ,
        .frame_cnt   (frame_cnt),
        .realign_cnt (realign_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: mode 0 idle, 1 waiting for frame_sync, 2 running; in RUN every output
    // follows from the distance to the cycle of the last chn-0 anchor.
    int               cyc, anchor, m_mode, m_frames, m_realigns;
    bit               m_busy, e_dv, e_sync, e_done;
    bit [1:0]         m_err;
    logic [7:0]       e_chn;
    logic [FCW_W-1:0] m_shadow [NUM_ANT][NUM_CHN];
    logic [FCW_W-1:0] m_active [NUM_ANT][NUM_CHN];

    task automatic model_reset();
        m_mode = 0; m_busy = 0; m_err = '0; m_frames = 0; m_realigns = 0;
        e_dv = 0; e_sync = 0; e_done = 0; e_chn = '0; anchor = 0;
        for (int a = 0; a < NUM_ANT; a++)
            for (int c = 0; c < NUM_CHN; c++) begin
                m_shadow[a][c] = '0;
                m_active[a][c] = '0;
            end
    endtask

    task automatic model_step();
        bit busy_pre, bnd;
        int mode_pre;
        cyc++;
        if (rst) begin
            model_reset();
            return;
        end
        busy_pre = m_busy;
        mode_pre = m_mode;
        if (fcw_wr) begin
            if (!busy_pre && int'(fcw_wr_ant) < NUM_ANT && int'(fcw_wr_chn) < NUM_CHN)
                m_shadow[fcw_wr_ant][fcw_wr_chn] = fcw_wr_data;
            else
                m_err[1] = 1'b1;
        end
        e_sync = 0;
        e_done = 0;
        if (!run_en) m_mode = 0;
        else if (m_mode == 0) m_mode = 1;
        else if (m_mode == 1) begin
            if (frame_sync) begin
                m_mode = 2; anchor = cyc; e_sync = 1;
            end
        end else if (frame_sync && ((cyc - anchor) % FRAME_CYC) != 0) begin
            anchor = cyc; e_sync = 1; m_err[0] = 1'b1;
            if (m_realigns < 65535) m_realigns++;
        end
        e_dv  = (m_mode == 2) && (((cyc - anchor) % CLK_PER_SLOT) == 0);
        e_chn = (m_mode == 2) ? 8'(((cyc - anchor) / CLK_PER_SLOT) % NUM_CHN) : 8'd0;
        bnd   = e_dv && (e_chn == 0);
        if (bnd) m_frames++;
        if (busy_pre ? (mode_pre != 2 || bnd) : (fcw_commit && mode_pre != 2)) begin
            m_active = m_shadow;
            m_busy = 0; e_done = 1;
            if (mode_pre == 2) e_sync = 1;
        end else if (fcw_commit) begin
            m_busy = 1;
        end
    endtask

    function automatic fcw_table_t model_table();
        fcw_table_t t;
        for (int a = 0; a < NUM_ANT; a++)
            for (int c = 0; c < NUM_CHN; c++)
                t[a][c] = m_active[a][c];
        return t;
    endfunction

    task automatic check(input string tag, input cmp_t obs, input cmp_t exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic compare_all();
        check("ddc_dv", cmp_t'(ddc_dv), cmp_t'(e_dv));
        check("ddc_chn", cmp_t'(ddc_chn), cmp_t'(e_chn));
        check("ddc_sync", cmp_t'(ddc_sync), cmp_t'(e_sync));
        check("fcw_busy", cmp_t'(fcw_busy), cmp_t'(m_busy));
        check("commit_done", cmp_t'(commit_done), cmp_t'(e_done));
        check("err_flags", cmp_t'(err_flags), cmp_t'(m_err));
        check("ddc_fcw", cmp_t'(ddc_fcw), cmp_t'(model_table()));
`ifdef PRACH_DDC_CTRL_STATS_EN
        check("frame_cnt", cmp_t'(frame_cnt), cmp_t'(32'(m_frames)));
        check("realign_cnt", cmp_t'(realign_cnt), cmp_t'(16'(m_realigns)));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        frame_sync = 1'b0;
        fcw_wr     = 1'b0;
        fcw_commit = 1'b0;
    endtask

    task automatic write(input int ant, input int chn, input logic [FCW_W-1:0] data);
        fcw_wr = 1'b1;
        fcw_wr_ant = 2'(ant);
        fcw_wr_chn = 8'(chn);
        fcw_wr_data = data;
    endtask

    initial begin
        logic [FCW_W-1:0] r00;
        rst = 1'b1; run_en = 1'b0; frame_sync = 1'b0; fcw_wr = 1'b0; fcw_commit = 1'b0;
        fcw_wr_ant = '0; fcw_wr_chn = '0; fcw_wr_data = '0;
        cyc = 0;
        model_reset();

        // Reset state, then start-up timing: strobe every CLK_PER_SLOT, sync only on the first.
        repeat (3) step();
        rst = 1'b0;
        step();
        run_en = 1'b1;
        step();
        step();
        frame_sync = 1'b1;
        step();
        check("t1_first_strobe", cmp_t'({ddc_dv, ddc_sync, ddc_chn}), cmp_t'({1'b1, 1'b1, 8'd0}));
        repeat (2 * FRAME_CYC) step();

        // Shadow writes, mid-frame commit lands exactly on the next chn-0 strobe.
        r00 = FCW_W'($urandom_range(0, 16'h7FFF));
        write(0, 0, r00);
        step();
        for (int i = 0; i < 5; i++) begin
            write($urandom_range(0, NUM_ANT - 1), $urandom_range(4, NUM_CHN - 1), FCW_W'($urandom));
            step();
        end
        for (int i = 0; i < FRAME_CYC && !(ddc_dv && ddc_chn == 8'd3); i++) step();
        write(1, 3, 16'h1234);
        step();
        fcw_commit = 1'b1;
        step();
        check("t2_busy_set", cmp_t'(fcw_busy), cmp_t'(1'b1));
        // Write while a commit is pending is dropped.
        write(0, 0, 16'hBEEF);
        step();
        check("t3_drop_flag", cmp_t'(err_flags[1]), cmp_t'(1'b1));
        for (int i = 0; i < 2 * FRAME_CYC && !commit_done; i++) step();
        check("t2_commit_strobe", cmp_t'({commit_done, ddc_sync, ddc_dv, ddc_chn}),
              cmp_t'({1'b1, 1'b1, 1'b1, 8'd0}));
        check("t2_fcw_1_3", cmp_t'(ddc_fcw[1][3]), cmp_t'(16'h1234));
        check("t3_fcw_0_0", cmp_t'(ddc_fcw[0][0]), cmp_t'(r00));
        repeat (3) step();

        // Misaligned frame_sync restarts the frame; an aligned one changes nothing.
        for (int i = 0; i < FRAME_CYC && !(ddc_dv && ddc_chn == 8'd5); i++) step();
        frame_sync = 1'b1;
        step();
        check("t4_realign", cmp_t'({ddc_sync, ddc_dv, ddc_chn, err_flags[0]}),
              cmp_t'({1'b1, 1'b1, 8'd0, 1'b1}));
        repeat (5) step();
        for (int i = 0; i < FRAME_CYC && ((cyc + 1 - anchor) % FRAME_CYC) != 0; i++) step();
        frame_sync = 1'b1;
        step();
        check("t4_aligned", cmp_t'({ddc_sync, ddc_dv, ddc_chn}), cmp_t'({1'b0, 1'b1, 8'd0}));

        // Disable mid-frame, restart, reset mid-frame, out-of-range write, idle commit.
        for (int i = 0; i < FRAME_CYC && !(ddc_dv && ddc_chn == 8'd4); i++) step();
        run_en = 1'b0;
        step();
        check("t5_dv_off", cmp_t'({ddc_dv, ddc_sync}), cmp_t'(2'b00));
        repeat (3) step();
        run_en = 1'b1;
        step();
        frame_sync = 1'b1;
        step();
        repeat (10) step();
        rst = 1'b1;
        step();
        check("t5_rst_all", cmp_t'({ddc_dv, ddc_chn, ddc_sync, err_flags, fcw_busy, commit_done}), cmp_t'(0));
        check("t5_rst_fcw", cmp_t'(ddc_fcw), cmp_t'(0));
        rst = 1'b0;
        run_en = 1'b0;
        write(3, 0, 16'h5555);
        step();
        check("t5_bad_ant", cmp_t'(err_flags), cmp_t'(2'b10));
        write(2, 6, 16'hA5C3);
        fcw_commit = 1'b1;
        step();
        check("t5_idle_commit", cmp_t'({commit_done, fcw_busy, ddc_fcw[2][6]}), cmp_t'({1'b1, 1'b0, 16'hA5C3}));

`ifdef PRACH_DDC_CTRL_STATS_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        run_en = 1'b1;
        step();
        frame_sync = 1'b1;
        step();
        repeat (2 * FRAME_CYC) step();
        check("t6_frame_cnt", cmp_t'(frame_cnt), cmp_t'(32'd3));
        repeat (6) step();
        frame_sync = 1'b1;
        step();
        check("t6_realign_cnt", cmp_t'(realign_cnt), cmp_t'(16'd1));
`endif

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 49) == 0) run_en = ~run_en;
            frame_sync = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 2) == 0)
                write($urandom_range(0, 3), $urandom_range(0, NUM_CHN + 1), FCW_W'($urandom));
            fcw_commit = ($urandom_range(0, 24) == 0);
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
